// File: rtl/issue_broadcaster.sv
// issue_broadcaster: streams one W x H x D image from image memory onto the
// shared allocator broadcast bus in Z/Y/X order (X innermost), one beat per
// cycle. A small skid FIFO decouples the one-cycle memory read latency from
// the stall input; read credit keeps that FIFO from ever overflowing.
module issue_broadcaster #(
  parameter int DATA_W     = 18,
  parameter int COORD_W    = 8,
  parameter int DEPTH_W    = 13,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  cfg_base,
  input  logic [COORD_W-1:0] cfg_width,
  input  logic [COORD_W-1:0] cfg_height,
  input  logic [DEPTH_W-1:0] cfg_depth,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0]  mem_rd_data,
  output logic [COORD_W-1:0] issue_x,
  output logic [COORD_W-1:0] issue_y,
  output logic [DATA_W-1:0]  issue_data,
  output logic               issue_blocked,
  input  logic               issue_block,
  output logic               busy,
  output logic               done
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH + 2) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t state_r, state_next_s;

  // latched frame configuration
  logic [COORD_W-1:0] w_r, h_r;
  logic [DEPTH_W-1:0] d_r;

  // read-side walker
  logic [COORD_W-1:0] rx_r, ry_r;
  logic [DEPTH_W-1:0] rz_r;
  logic [ADDR_W-1:0]  addr_r;
  logic               issued_all_r;

  // read response tracking: coordinates travel alongside the read
  logic               inflight_r;
  logic [COORD_W-1:0] fx_r, fy_r;
  logic               flast_r;

  // skid FIFO storage
  logic [COORD_W-1:0] fifo_x_r    [FIFO_DEPTH];
  logic [COORD_W-1:0] fifo_y_r    [FIFO_DEPTH];
  logic [DATA_W-1:0]  fifo_d_r    [FIFO_DEPTH];
  logic               fifo_last_r [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_r, wr_ptr_r;
  logic [CW-1:0]      count_r;

  logic          start_ok_s, zero_cfg_s, read_last_s;
  logic          push_s, pop_s, last_pop_s;
  logic [CW-1:0] occ_s;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // bus, credit and frame-boundary decode
  always_comb begin
    start_ok_s    = (state_r == IDLE) && start;
    zero_cfg_s    = (cfg_width == '0) || (cfg_height == '0) || (cfg_depth == '0);
    read_last_s   = (rx_r == w_r - COORD_W'(1)) && (ry_r == h_r - COORD_W'(1)) &&
                    (rz_r == d_r - DEPTH_W'(1));
    issue_blocked = (count_r == '0) || issue_block;
    pop_s         = !issue_blocked;
    push_s        = inflight_r;
    last_pop_s    = pop_s && fifo_last_r[rd_ptr_r];
    occ_s         = count_r + CW'(inflight_r) - CW'(pop_s);
    mem_rd_en     = (state_r == RUN) && !issued_all_r && (occ_s < CW'(FIFO_DEPTH));
    mem_addr      = addr_r;
    issue_x       = fifo_x_r[rd_ptr_r];
    issue_y       = fifo_y_r[rd_ptr_r];
    issue_data    = fifo_d_r[rd_ptr_r];
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_next_s;
  end

  // next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    if (start) state_next_s = zero_cfg_s ? DONE : RUN;
               else       state_next_s = IDLE;
      RUN:     if (last_pop_s) state_next_s = DONE;
               else            state_next_s = RUN;
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    case (state_r)
      RUN:     begin busy = 1'b1; done = 1'b0; end
      DONE:    begin busy = 1'b0; done = 1'b1; end
      default: begin busy = 1'b0; done = 1'b0; end
    endcase
  end

  // config latch and Z/Y/X read walker with incrementing address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_r <= '0; h_r <= '0; d_r <= '0;
      rx_r <= '0; ry_r <= '0; rz_r <= '0;
      addr_r <= '0; issued_all_r <= 1'b0;
    end else if (start_ok_s) begin
      w_r <= cfg_width; h_r <= cfg_height; d_r <= cfg_depth;
      rx_r <= '0; ry_r <= '0; rz_r <= '0;
      addr_r <= cfg_base; issued_all_r <= 1'b0;
    end else if (mem_rd_en) begin
      addr_r       <= addr_r + ADDR_W'(1);
      issued_all_r <= read_last_s;
      if (rx_r == w_r - COORD_W'(1)) begin
        rx_r <= '0;
        if (ry_r == h_r - COORD_W'(1)) begin
          ry_r <= '0;
          rz_r <= rz_r + DEPTH_W'(1);
        end else begin
          ry_r <= ry_r + COORD_W'(1);
        end
      end else begin
        rx_r <= rx_r + COORD_W'(1);
      end
    end else begin
      issued_all_r <= issued_all_r;
    end
  end

  // in-flight read tag, aligned with the returning memory word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_r <= 1'b0; fx_r <= '0; fy_r <= '0; flast_r <= 1'b0;
    end else begin
      inflight_r <= mem_rd_en;
      fx_r       <= rx_r;
      fy_r       <= ry_r;
      flast_r    <= read_last_s;
    end
  end

  // skid FIFO: push returning words, pop on each transferred beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_x_r[i] <= '0; fifo_y_r[i] <= '0;
        fifo_d_r[i] <= '0; fifo_last_r[i] <= 1'b0;
      end
      rd_ptr_r <= '0; wr_ptr_r <= '0; count_r <= '0;
    end else begin
      if (push_s) begin
        fifo_x_r[wr_ptr_r]    <= fx_r;
        fifo_y_r[wr_ptr_r]    <= fy_r;
        fifo_d_r[wr_ptr_r]    <= mem_rd_data;
        fifo_last_r[wr_ptr_r] <= flast_r;
        wr_ptr_r              <= next_ptr(wr_ptr_r);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) rd_ptr_r <= next_ptr(rd_ptr_r);
      else       rd_ptr_r <= rd_ptr_r;
      count_r <= count_r + CW'(push_s) - CW'(pop_s);
    end
  end

endmodule

// File: tb/tb_issue_broadcaster.sv
// Directed bench for issue_broadcaster: a behavioural image memory answers
// reads one cycle later; each scenario task checks the bus, the read address
// sequence and the done timing against hand-derived expectations.
module tb_issue_broadcaster;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] cfg_base;
  logic [7:0]  cfg_width, cfg_height;
  logic [12:0] cfg_depth;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [17:0] mem_rd_data;
  logic [7:0]  issue_x, issue_y;
  logic [17:0] issue_data;
  logic        issue_blocked;
  logic        issue_block;
  logic        busy, done;

  int total = 0;
  int bad   = 0;

  issue_broadcaster dut (
    .clk(clk), .rst(rst), .start(start), .cfg_base(cfg_base),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_depth(cfg_depth),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .issue_x(issue_x), .issue_y(issue_y), .issue_data(issue_data),
    .issue_blocked(issue_blocked), .issue_block(issue_block),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] memval(input logic [15:0] a);
    return {a[15:14], a} ^ 18'h2C3A5;
  endfunction

  // image memory with one-cycle read latency
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= memval(mem_addr);
  end

  task automatic check_reset_values(input string name);
    total++;
    if (mem_rd_en !== 1'b0 || mem_addr !== 16'h0 || issue_x !== 8'h0 ||
        issue_y !== 8'h0 || issue_data !== 18'h0 || issue_blocked !== 1'b1 ||
        busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL %s: rd_en=%b addr=%h x=%h y=%h data=%h blocked=%b busy=%b done=%b, required 0 0 0 0 0 1 0 0",
               name, mem_rd_en, mem_addr, issue_x, issue_y, issue_data, issue_blocked, busy, done);
    end
  endtask

  // Starts a frame and follows it to done. Cycle 0 is the start cycle.
  task automatic run_frame(input logic [15:0] base, input logic [7:0] w, input logic [7:0] h,
                           input logic [12:0] d, input int blk_from, input int blk_len,
                           input int restart_at, input int exp_done, input string name);
    int beats, reads, n_beats, done_cyc;
    logic [7:0]  ex, ey;
    logic [17:0] ed;
    logic [15:0] ea;
    n_beats = int'(w) * int'(h) * int'(d);
    beats = 0; reads = 0; done_cyc = -1;
    @(negedge clk);
    cfg_base = base; cfg_width = w; cfg_height = h; cfg_depth = d; start = 1'b1;
    for (int cyc = 1; cyc <= 300 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      start = (cyc == restart_at);
      if (cyc == restart_at) begin
        cfg_base = 16'h5000; cfg_width = 8'd3; cfg_height = 8'd3; cfg_depth = 13'd1;
      end
      issue_block = (cyc >= blk_from) && (cyc < blk_from + blk_len);
      #1;
      ex = 8'(beats % int'(w));
      ey = 8'((beats / int'(w)) % int'(h));
      ed = memval(16'(base + 16'(beats)));
      if (issue_block) begin
        total++;
        if (issue_blocked !== 1'b1 || issue_x !== ex || issue_y !== ey || issue_data !== ed) begin
          bad++;
          $display("FAIL %s hold c%0d: blocked=%b x=%0d y=%0d data=%h, required 1 %0d %0d %h",
                   name, cyc, issue_blocked, issue_x, issue_y, issue_data, ex, ey, ed);
        end
      end
      if (mem_rd_en === 1'b1) begin
        ea = 16'(base + 16'(reads));
        total++;
        if (mem_addr !== ea) begin
          bad++;
          $display("FAIL %s addr read %0d: got %h, required %h", name, reads, mem_addr, ea);
        end
        reads++;
      end
      if (issue_blocked === 1'b0) begin
        total++;
        if (beats >= n_beats) begin
          bad++;
          $display("FAIL %s extra beat c%0d: got beat %0d, required at most %0d", name, cyc, beats + 1, n_beats);
        end else if (issue_x !== ex || issue_y !== ey || issue_data !== ed) begin
          bad++;
          $display("FAIL %s beat %0d: got x=%0d y=%0d data=%h, required %0d %0d %h",
                   name, beats, issue_x, issue_y, issue_data, ex, ey, ed);
        end
        beats++;
      end
      total++;
      if (dut.count_r > 2) begin
        bad++;
        $display("FAIL %s fifo count c%0d: got %0d, required <= 2", name, cyc, dut.count_r);
      end
      if (done === 1'b1) begin
        done_cyc = cyc;
        total++;
        if (cyc != exp_done || busy !== 1'b0) begin
          bad++;
          $display("FAIL %s done: got cycle %0d busy=%b, required cycle %0d busy=0", name, cyc, busy, exp_done);
        end
      end
    end
    issue_block = 1'b0;
    start = 1'b0;
    total++;
    if (done_cyc < 0 || beats != n_beats || reads != n_beats) begin
      bad++;
      $display("FAIL %s totals: done_cycle=%0d beats=%0d reads=%0d, required done and %0d beats/reads",
               name, done_cyc, beats, reads, n_beats);
    end
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    check_reset_values("reset");
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_frame(16'h0100, 8'd2, 8'd2, 13'd2, -1, 0, -1, 11, "basic_2x2x2");
  endtask

  task automatic test_block();
    run_frame(16'h0100, 8'd2, 8'd2, 13'd2, 6, 3, -1, 14, "block_3");
  endtask

  task automatic test_zero_depth();
    run_frame(16'h0040, 8'd2, 8'd2, 13'd0, -1, 0, -1, 1, "zero_depth");
    run_frame(16'h0040, 8'd0, 8'd3, 13'd1, -1, 0, -1, 1, "zero_width");
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    cfg_base = 16'h0200; cfg_width = 8'd4; cfg_height = 8'd4; cfg_depth = 13'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (7) @(negedge clk);
    #1;
    total++;
    if (issue_blocked !== 1'b0 || issue_x !== 8'd1 || issue_y !== 8'd1) begin
      bad++;
      $display("FAIL beat5 before reset: blocked=%b x=%0d y=%0d, required 0 1 1", issue_blocked, issue_x, issue_y);
    end
    rst = 1'b1; #1;
    check_reset_values("mid_frame_reset");
    @(negedge clk); rst = 1'b0;
    run_frame(16'h0200, 8'd4, 8'd4, 13'd1, -1, 0, -1, 19, "after_reset_4x4");
  endtask

  task automatic test_restart_ignored();
    run_frame(16'h0300, 8'd2, 8'd2, 13'd2, -1, 0, 5, 11, "restart_ignored");
  endtask

  task automatic test_addr_wrap();
    run_frame(16'hFFFE, 8'd4, 8'd1, 13'd1, -1, 0, -1, 7, "addr_wrap");
  endtask

  task automatic test_back_to_back();
    run_frame(16'h0010, 8'd3, 8'd2, 13'd1, -1, 0, -1, 9, "b2b_first");
    run_frame(16'h0020, 8'd1, 8'd1, 13'd3, -1, 0, -1, 6, "b2b_second");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; issue_block = 1'b0;
    cfg_base = 16'h0; cfg_width = 8'h0; cfg_height = 8'h0; cfg_depth = 13'h0;
    test_reset();
    test_basic();
    test_block();
    test_zero_depth();
    test_reset_mid_frame();
    test_restart_ignored();
    test_addr_wrap();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
